// File: rtl/power_result_buffer_pkg.sv
// power_result_buffer_pkg
//   Shared constants for the power-of-8 pipeline and its flow-control shell.
//   The pipeline and the result buffer both take their widths and latency
//   from here, so the tag shift register can never disagree with the number
//   of register stages in the pipeline.
//
//   PWR_DATA_W   : result width produced by the pipeline
//   PWR_OP_W     : operand width consumed by the pipeline
//   PWR_LATENCY  : register stages from operand to result
//   RESULT_DEPTH : default result FIFO depth (power of two, >= PWR_LATENCY+2
//                  so a steady stream never loses throughput to credit)
package power_result_buffer_pkg;

    localparam int PWR_DATA_W   = 32;
    localparam int PWR_OP_W     = 8;
    localparam int PWR_LATENCY  = 3;
    localparam int RESULT_DEPTH = 8;

endpackage

// File: rtl/power_result_fifo.sv
// power_result_fifo
//   Synchronous first-word-fall-through FIFO holding pipeline results until
//   the consumer takes them. rd_data always shows the head entry; it is only
//   meaningful while level is non-zero.
//
//   clk      in   clock
//   reset_n  in   asynchronous, active-low reset (clears pointers and level)
//   wr_en    in   push wr_data at this edge
//   wr_data  in   entry to push
//   rd_en    in   pop the head entry at this edge
//   rd_data  out  head entry
//   level    out  number of stored entries, 0..DEPTH
//   full     out  level == DEPTH
//
//   A push while full is accepted only when a pop happens in the same edge;
//   otherwise it is ignored. A pop while empty is ignored.
module power_result_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign full    = (level == LVL_W'(DEPTH));
    assign rd_data = mem[rd_ptr];

    // A pop frees the slot at the same edge, so a push into a full FIFO is
    // safe exactly when it is paired with a pop.
    assign do_rd = rd_en && (level != '0);
    assign do_wr = wr_en && (!full || do_rd);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage carries no reset; stale contents are never visible because
    // level gates every read.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/power_result_buffer.sv
// power_result_buffer
//   Flow-control shell around the free-running power-of-8 pipeline. Operands
//   arrive on a valid/ready slave port and go straight to the pipeline. A
//   tag shift register, as deep as the pipeline, remembers which pipeline
//   slots hold real operands; when a tag reaches the end, the pipeline output
//   is captured into the result FIFO. Results leave on a valid/ready master
//   port in acceptance order.
//
//   clk           in   clock
//   reset_n       in   asynchronous, active-low reset (shared with pipeline)
//   s_valid       in   operand valid
//   s_ready       out  operand may be accepted (credit available)
//   s_data        in   operand
//   p_operand     out  pipeline input, always s_data
//   p_result      in   pipeline output
//   m_valid       out  result available at m_data
//   m_ready       in   consumer takes the result this edge
//   m_data        out  oldest buffered result
//   level         out  FIFO occupancy
//   err_overflow  out  sticky: a tagged result arrived with no room for it
module power_result_buffer
    import power_result_buffer_pkg::*;
#(
    parameter int DATA_W  = PWR_DATA_W,
    parameter int OP_W    = PWR_OP_W,
    parameter int LATENCY = PWR_LATENCY,
    parameter int DEPTH   = RESULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [OP_W-1:0]          s_data,
    output logic [OP_W-1:0]          p_operand,
    input  logic [DATA_W-1:0]        p_result,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err_overflow
);

    // Wide enough to hold a full FIFO plus a full pipeline of tags.
    localparam int TOT_W = $clog2(DEPTH + LATENCY + 1);

    logic [LATENCY-1:0] tag;
    logic               acc;
    logic               rd_en;
    logic               wr_tag;
    logic               fifo_full;
    logic [TOT_W-1:0]   inflight;
    logic [TOT_W-1:0]   total;

    // The pipeline never stalls, so the operand is forwarded unconditionally;
    // the tag alone decides whether its result is kept.
    assign p_operand = s_data;

    assign acc     = s_valid && s_ready;
    assign m_valid = (level != '0);
    assign rd_en   = m_valid && m_ready;
    assign wr_tag  = tag[LATENCY-1];

    // Tag shift register advances every edge, in lock-step with the pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag <= '0;
        end else begin
            tag <= (tag << 1) | LATENCY'(acc);
        end
    end

    // Credit: every accepted operand owns a FIFO slot from the moment it is
    // accepted until it is popped. Only registered state feeds s_ready, so a
    // pop returns its credit one cycle later and m_ready never reaches s_ready
    // combinationally.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + TOT_W'(tag[i]);
        end
        total   = inflight + TOT_W'(level);
        s_ready = (total < TOT_W'(DEPTH));
    end

    // Credit makes this unreachable; it is kept as a sticky alarm in case
    // the pipeline or credit logic is ever mis-sized.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_overflow <= 1'b0;
        end else if (wr_tag && fifo_full && !rd_en) begin
            err_overflow <= 1'b1;
        end
    end

    power_result_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_tag),
        .wr_data (p_result),
        .rd_en   (rd_en),
        .rd_data (m_data),
        .level   (level),
        .full    (fifo_full)
    );

endmodule
